csr_regfile: RTL and testbench

//   Downstream consumer of the CSR decode stage: the 16-entry CSR bank addressed by csr_sel.

---
 rtl/csr_pkg.sv | 30 +++
 rtl/csr_regfile_if.sv | 21 ++
 rtl/csr_counter64.sv | 24 ++
 rtl/csr_regfile.sv | 104 ++++++++++
 tb/tb_csr_regfile.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared constants and decode helpers for the CSR bank: counter indices,
// read-modify-write encodings and the map from csr_sel to scratch slot.
package csr_pkg;

  localparam logic [3:0] CSR_CYCLE    = 4'd0;
  localparam logic [3:0] CSR_TIME     = 4'd1;
  localparam logic [3:0] CSR_INSTRET  = 4'd2;
  localparam logic [3:0] CSR_CYCLEH   = 4'd8;
  localparam logic [3:0] CSR_TIMEH    = 4'd9;
  localparam logic [3:0] CSR_INSTRETH = 4'd10;

  localparam logic [1:0] RW_READ  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_SET   = 2'b10;
  localparam logic [1:0] RW_CLEAR = 2'b11;

  localparam int unsigned SCRATCH_N = 10;

  function automatic logic is_counter(input logic [3:0] sel);
    return (sel == CSR_CYCLE)  || (sel == CSR_TIME)  || (sel == CSR_INSTRET) ||
           (sel == CSR_CYCLEH) || (sel == CSR_TIMEH) || (sel == CSR_INSTRETH);
  endfunction

  // Scratch indices 3-7 land in slots 0-4, 11-15 in slots 5-9; counters map to 0 (unused).
  function automatic logic [3:0] scratch_idx(input logic [3:0] sel);
    if (sel < 4'd8) return (sel < 4'd3) ? 4'd0 : sel - 4'd3;
    return (sel < 4'd11) ? 4'd0 : sel - 4'd6;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Access bus between the CSR decode stage (master) and the CSR bank (slave).
interface csr_regfile_if;
  logic [3:0]  csr_sel;
  logic [1:0]  rw_mode;
  logic        csr_rd;
  logic [31:0] csr_wdata;
  logic        instr_retired;
  logic [31:0] csr_rdata;
  logic        rdata_valid;
  logic        csr_illegal;

  modport master (
    output csr_sel, rw_mode, csr_rd, csr_wdata, instr_retired,
    input  csr_rdata, rdata_valid, csr_illegal
  );

  modport slave (
    input  csr_sel, rw_mode, csr_rd, csr_wdata, instr_retired,
    output csr_rdata, rdata_valid, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// Free-running 64-bit counter; a single 64-bit add carries low into high
// within the same cycle and wraps silently at 2^64.
module csr_counter64 #(
  parameter logic [63:0] RST_VAL = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [63:0] value
);
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign value = cnt_q;
endmodule

// File: rtl/csr_regfile.sv
// 16-entry CSR bank: read-only Zicntr counters plus ten R/W scratch registers,
// with registered old-value readback one cycle after each access.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned TIME_DIV    = 10,
  parameter logic [31:0] SCRATCH_RST = 32'd0,
  // Reset value of the cycle counter; 0 gives standard Zicntr behaviour.
  parameter logic [63:0] CYCLE_RST   = 64'd0
) (
  input logic           clk,
  input logic           reset,
  csr_regfile_if.slave  bus
);
  localparam int unsigned PS_W = $clog2(TIME_DIV) + 1;

  logic [PS_W-1:0] ps_q, ps_d;
  logic            time_tick;
  logic [63:0]     cycle_val, time_val, instret_val;

  logic [31:0] scratch_q [SCRATCH_N];
  logic [31:0] scratch_d [SCRATCH_N];
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  slot;
  logic        counter_hit;
  logic        write_req;
  logic [31:0] old_val;
  logic [31:0] new_val;

  assign time_tick = (ps_q == PS_W'(TIME_DIV - 1));

  always_comb begin
    ps_d = time_tick ? '0 : ps_q + PS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ps_q <= '0;
    else       ps_q <= ps_d;
  end

  csr_counter64 #(.RST_VAL(CYCLE_RST)) u_cycle (
    .clk(clk), .reset(reset), .inc(1'b1), .value(cycle_val)
  );

  csr_counter64 u_time (
    .clk(clk), .reset(reset), .inc(time_tick), .value(time_val)
  );

  csr_counter64 u_instret (
    .clk(clk), .reset(reset), .inc(bus.instr_retired), .value(instret_val)
  );

  always_comb begin
    slot        = scratch_idx(bus.csr_sel);
    counter_hit = is_counter(bus.csr_sel);
    write_req   = (bus.rw_mode != RW_READ);

    case (bus.csr_sel)
      CSR_CYCLE:    old_val = cycle_val[31:0];
      CSR_TIME:     old_val = time_val[31:0];
      CSR_INSTRET:  old_val = instret_val[31:0];
      CSR_CYCLEH:   old_val = cycle_val[63:32];
      CSR_TIMEH:    old_val = time_val[63:32];
      CSR_INSTRETH: old_val = instret_val[63:32];
      default:      old_val = scratch_q[slot];
    endcase

    case (bus.rw_mode)
      RW_WRITE: new_val = bus.csr_wdata;
      RW_SET:   new_val = old_val | bus.csr_wdata;
      RW_CLEAR: new_val = old_val & ~bus.csr_wdata;
      default:  new_val = old_val;
    endcase

    scratch_d = scratch_q;
    if (write_req && !counter_hit) scratch_d[slot] = new_val;

    // Readback always reflects the pre-write, pre-increment value.
    rdata_d   = bus.csr_rd ? old_val : rdata_q;
    valid_d   = bus.csr_rd;
    illegal_d = write_req && counter_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SCRATCH_N; i++) scratch_q[i] <= SCRATCH_RST;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.csr_rdata   = rdata_q;
  assign bus.rdata_valid = valid_q;
  assign bus.csr_illegal = illegal_q;
endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: per-cycle compare against a behavioural
// model plus directed vectors with literal expectations.
module tb_csr_regfile;
  localparam int unsigned TD1 = 4;

  logic clk;
  logic rst1, rst2;
  int   n_checks = 0;
  int   errs     = 0;

  csr_regfile_if bus1 ();
  csr_regfile_if bus2 ();

  csr_regfile #(.TIME_DIV(TD1), .SCRATCH_RST(32'd0), .CYCLE_RST(64'd0)) u_dut (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  csr_regfile #(.TIME_DIV(1), .SCRATCH_RST(32'hDEAD_BEEF),
                .CYCLE_RST(64'h0000_0000_FFFF_FFFF)) u_dut2 (
    .clk(clk), .reset(rst2), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of DUT1 ----------------
  logic [63:0] m_ticks, m_ret;
  logic [31:0] m_scr [16];
  logic [31:0] exp_rdata;
  logic        exp_valid, exp_ill, m_live;

  function automatic logic [31:0] m_read(input logic [3:0] sel);
    logic [63:0] cyc, tim;
    cyc = m_ticks;
    tim = m_ticks / TD1;
    case (sel)
      4'd0:    return cyc[31:0];
      4'd1:    return tim[31:0];
      4'd2:    return m_ret[31:0];
      4'd8:    return cyc[63:32];
      4'd9:    return tim[63:32];
      4'd10:   return m_ret[63:32];
      default: return m_scr[sel];
    endcase
  endfunction

  initial begin
    logic [3:0]  sel;
    logic [1:0]  mode;
    logic [31:0] old;
    logic        ctr;
    m_live = 1'b0;
    forever begin
      @(posedge clk);
      if (rst1) begin
        m_ticks = 0;
        m_ret   = 0;
        for (int i = 0; i < 16; i++) m_scr[i] = 32'd0;
        exp_rdata = 0;
        exp_valid = 0;
        exp_ill   = 0;
        m_live    = 1'b1;
      end else begin
        sel  = bus1.csr_sel;
        mode = bus1.rw_mode;
        ctr  = sel inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10};
        old  = m_read(sel);
        exp_valid = bus1.csr_rd;
        if (bus1.csr_rd) exp_rdata = old;
        exp_ill = (mode != 2'b00) && ctr;
        if (mode != 2'b00 && !ctr) begin
          case (mode)
            2'b01:   m_scr[sel] = bus1.csr_wdata;
            2'b10:   m_scr[sel] = old | bus1.csr_wdata;
            default: m_scr[sel] = old & ~bus1.csr_wdata;
          endcase
        end
        m_ticks = m_ticks + 1;
        if (bus1.instr_retired) m_ret = m_ret + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("model_rdata", bus1.csr_rdata, exp_rdata);
        check("model_valid", bus1.rdata_valid, exp_valid);
        check("model_illegal", bus1.csr_illegal, exp_ill);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic [3:0] sel, input logic [1:0] mode, input logic rd,
                     input logic [31:0] wd, input logic ir);
    bus1.csr_sel       = sel;
    bus1.rw_mode       = mode;
    bus1.csr_rd        = rd;
    bus1.csr_wdata     = wd;
    bus1.instr_retired = ir;
    @(negedge clk);
  endtask

  task automatic idle(input logic ir);
    acc(4'd0, 2'b00, 1'b0, 32'd0, ir);
  endtask

  task automatic acc2(input logic [3:0] sel);
    bus2.csr_sel       = sel;
    bus2.rw_mode       = 2'b00;
    bus2.csr_rd        = 1'b1;
    bus2.csr_wdata     = 32'd0;
    bus2.instr_retired = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pat;
    rst1 = 1'b1;
    rst2 = 1'b1;
    bus2.csr_sel = 4'd0; bus2.rw_mode = 2'b00; bus2.csr_rd = 1'b0;
    bus2.csr_wdata = 32'd0; bus2.instr_retired = 1'b0;
    idle(1'b0);
    idle(1'b0);
    check("reset_rdata", bus1.csr_rdata, 32'd0);
    check("reset_valid", bus1.rdata_valid, 1'b0);

    // Test 1: cycle counter from reset release
    rst1 = 1'b0;
    acc(4'd0, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t1_cycle_first", bus1.csr_rdata, 32'd0);
    check("t1_valid", bus1.rdata_valid, 1'b1);
    repeat (4) idle(1'b0);
    acc(4'd0, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t1_cycle_5", bus1.csr_rdata, 32'd5);

    // Test 2: scratch write / set / clear
    acc(4'd3, 2'b01, 1'b1, 32'hA5A5_0000, 1'b0);
    check("t2_write_old", bus1.csr_rdata, 32'd0);
    acc(4'd3, 2'b10, 1'b1, 32'h0000_00FF, 1'b0);
    check("t2_set_old", bus1.csr_rdata, 32'hA5A5_0000);
    acc(4'd3, 2'b11, 1'b1, 32'hA000_0000, 1'b0);
    check("t2_clear_old", bus1.csr_rdata, 32'hA5A5_00FF);
    acc(4'd3, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t2_final", bus1.csr_rdata, 32'h05A5_00FF);

    // Test 3: writes to read-only counters
    acc(4'd8, 2'b01, 1'b1, 32'h0000_1234, 1'b0);
    check("t3_illegal", bus1.csr_illegal, 1'b1);
    check("t3_cycleh_old", bus1.csr_rdata, 32'd0);
    acc(4'd8, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t3_read_legal", bus1.csr_illegal, 1'b0);
    check("t3_cycleh_kept", bus1.csr_rdata, 32'd0);
    acc(4'd1, 2'b10, 1'b0, 32'd0, 1'b0);
    check("t3_set_zero_illegal", bus1.csr_illegal, 1'b1);
    check("t3_no_rd_valid", bus1.rdata_valid, 1'b0);

    // Sweep every index with each rw_mode, then read back (model-checked)
    for (int s = 0; s < 16; s++) begin
      pat = {8{s[3:0]}};
      acc(s[3:0], 2'b01, 1'b1, pat, s[0]);
      acc(s[3:0], 2'b10, s[1], 32'h0F00_00F0, 1'b0);
      acc(s[3:0], 2'b11, 1'b1, 32'h0000_0F0F, 1'b1);
    end
    for (int s = 0; s < 16; s++) acc(s[3:0], 2'b00, 1'b1, 32'd0, 1'b0);
    idle(1'b0);

    // Test 5: time prescaler and instret
    rst1 = 1'b1;
    idle(1'b0);
    rst1 = 1'b0;
    repeat (12) idle(1'b0);
    acc(4'd1, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t5_time_3", bus1.csr_rdata, 32'd3);
    idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b0);
    idle(1'b1); idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b1);
    acc(4'd2, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t5_instret_7", bus1.csr_rdata, 32'd7);
    acc(4'd10, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t5_instreth_0", bus1.csr_rdata, 32'd0);

    // Test 6: reset during a write
    acc(4'd4, 2'b01, 1'b1, 32'h5555_AAAA, 1'b0);
    rst1 = 1'b1;
    acc(4'd4, 2'b01, 1'b1, 32'h1111_2222, 1'b1);
    check("t6_valid_low", bus1.rdata_valid, 1'b0);
    check("t6_illegal_low", bus1.csr_illegal, 1'b0);
    rst1 = 1'b0;
    acc(4'd0, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t6_cycle_0", bus1.csr_rdata, 32'd0);
    acc(4'd2, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t6_instret_0", bus1.csr_rdata, 32'd0);
    acc(4'd4, 2'b00, 1'b1, 32'd0, 1'b0);
    check("t6_scratch_rst", bus1.csr_rdata, 32'd0);
    idle(1'b0);

    // Test 4: low-to-high carry on a preloaded cycle counter (second instance)
    rst2 = 1'b0;
    acc2(4'd0);
    check("t4_cycle_lo", bus2.csr_rdata, 32'hFFFF_FFFF);
    acc2(4'd8);
    check("t4_cycle_hi", bus2.csr_rdata, 32'd1);
    acc2(4'd1);
    check("t4_time_div1", bus2.csr_rdata, 32'd2);
    acc2(4'd7);
    check("t4_scratch_rst", bus2.csr_rdata, 32'hDEAD_BEEF);
    acc2(4'd0);
    check("t4_cycle_lo_wrapped", bus2.csr_rdata, 32'd3);

    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end
endmodule
